fifo_byte_reader: RTL and testbench
===================================

# fifo_byte_reader

Read-side drain for the design's synchronous word FIFOs. It pops DATA_WIDTH-bit words from a FIFO whose read data is registered one cycle after the read strobe, and emits them as a valid/ready byte stream, least-significant byte first. Two word slots (current and prefetch) plus in-flight read tracking sustain one byte per cycle. It never over-reads an empty FIFO and never drops a popped word.

## Interface
Parameters:
- DATA_WIDTH, 32, FIFO word width; multiple of 8, ≥8
- BYTES, DATA_WIDTH/8, derived bytes per word (not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  permits new FIFO pops; buffered words drain regardless
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO pop strobe (one word per high cycle)
- fifo_data  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en
- m_data  out  8  output byte
- m_valid  out  1  m_data valid
- m_ready  in  1  sink accepts byte
- m_last  out  1  m_data is byte BYTES-1 of its word
- busy  out  1  cur_valid | pf_valid | pending
- word_cnt  out  16  words popped since reset, wraps

## Operation
- State: cur (word, cur_valid, byte_idx 0..BYTES-1), pf (word, pf_valid), pending (read issued last cycle).
- fifo_rd_en = !rst & enable & !fifo_empty & (cur_valid + pf_valid + pending < 2); combinational from registered state and inputs.
- pending <= fifo_rd_en each cycle; word_cnt <= word_cnt+1 (mod 2^16) when fifo_rd_en.
- m_valid = cur_valid; m_data = cur[8*byte_idx +: 8]; m_last = m_valid & (byte_idx == BYTES-1).
- Handshake = m_valid & m_ready. On handshake with byte_idx < BYTES-1: byte_idx++.
- On handshake with byte_idx == BYTES-1 (word done): byte_idx <= 0; cur <= pf if pf_valid, else fifo_data if pending, else cur_valid <= 0.
- Arriving word (pending) when not consumed by the word-done refill: goes to cur if cur_valid==0, else to pf (pf_valid <= 1). If pf fed cur this cycle and pending, the arriving word goes to pf. The capacity rule guarantees a free slot; overflow is impossible.
- enable low: no new pops; an in-flight read still lands; cur/pf drain normally.
- m_data/m_last held stable while m_valid & !m_ready.
- Byte order: byte 0 = fifo_data[7:0] first.

## Timing
- Reset values: m_valid 0, m_data 0x00, m_last 0, fifo_rd_en 0, busy 0, word_cnt 0, byte_idx 0, all slot-valid and pending flags 0.
- Reset mid-operation clears cur, pf, and pending immediately; buffered and in-flight words are discarded. The FIFO is reset by the same rst.
- Latency: fifo_rd_en high in cycle N → fifo_data sampled at end of N+1 → m_valid high in N+2 (if cur empty).
- Throughput with m_ready held 1 and FIFO non-empty: one byte/cycle for BYTES ≥ 2, one byte per ≤2 cycles for BYTES = 1.
- fifo_rd_en is never high while fifo_empty=1 in the same cycle.
- word_cnt 0xFFFF + pop → 0x0000.

## Test plan
- Basic: FIFO holds 0x44332211; m_ready=1 → fifo_rd_en 1 cycle; bytes 11,22,33,44 on 4 consecutive cycles starting 2 cycles after pop; m_last only on 44; busy falls after 44.
- Streaming: 8 words, m_ready=1 → 32 bytes in 32 consecutive cycles after initial 2-cycle latency; no m_valid gaps; word_cnt=8.
- Backpressure: m_ready toggles pseudo-randomly → byte sequence identical to FIFO order; m_data stable while stalled; pops stop at cur+pf+pending=2; no word lost.
- Empty/underflow: FIFO empties mid-stream → fifo_rd_en never high with fifo_empty=1; m_valid drops after last byte; resumes correctly on refill.
- Enable: drop enable with one read in flight → that word plus buffered words still emitted; no further pops until enable returns.
- Reset mid-word: assert rst after byte 2 of a word with pf full → all outputs at reset values asynchronously; after release with a fresh FIFO word 0xDDCCBBAA → DD..AA order AA,BB,CC,DD, word_cnt=1.

Source files
------------

// File: rtl/fifo_byte_reader_if.sv
// Signal bundle between the FIFO read side, the byte reader and the byte sink.
// The master view belongs to the reader. It pops words from the FIFO and drives the byte stream.
// The slave view belongs to the environment around the reader.
interface fifo_byte_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_enable;
  logic                  i_fifo_empty;
  logic                  o_fifo_rd_en;
  logic [DATA_WIDTH-1:0] i_fifo_data;
  logic [7:0]            o_m_data;
  logic                  o_m_valid;
  logic                  i_m_ready;
  logic                  o_m_last;
  logic                  o_busy;
  logic [15:0]           o_word_cnt;

  modport master (
    input  i_enable,
    input  i_fifo_empty,
    input  i_fifo_data,
    input  i_m_ready,
    output o_fifo_rd_en,
    output o_m_data,
    output o_m_valid,
    output o_m_last,
    output o_busy,
    output o_word_cnt
  );

  modport slave (
    output i_enable,
    output i_fifo_empty,
    output i_fifo_data,
    output i_m_ready,
    input  o_fifo_rd_en,
    input  o_m_data,
    input  o_m_valid,
    input  o_m_last,
    input  o_busy,
    input  o_word_cnt
  );
endinterface

// File: rtl/fifo_byte_reader.sv
// Drains a registered-output word FIFO into a valid/ready byte stream, LSB first.
// The reader holds two word slots: the current word being emitted and one prefetched word.
// It also tracks a read that is still in flight.
// Together these keep one byte per cycle flowing without over-reading the FIFO.
module fifo_byte_reader #(
  parameter int DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  fifo_byte_reader_if.master bus
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BYTES - 1);

  logic [DATA_WIDTH-1:0] r_cur;
  logic [DATA_WIDTH-1:0] r_pf;
  logic                  r_cur_valid;
  logic                  r_pf_valid;
  logic                  r_pending;
  logic [IDXW-1:0]       r_byte_idx;
  logic [15:0]           r_word_cnt;

  logic [1:0]            w_occ;
  logic                  w_rd_en;
  logic                  w_hs;
  logic                  w_word_done;
  logic [DATA_WIDTH-1:0] w_shift;

  // Words already owned or on their way; at most two may exist so a slot is always free for an arrival.
  assign w_occ       = {1'b0, r_cur_valid} + {1'b0, r_pf_valid} + {1'b0, r_pending};
  assign w_rd_en     = !rst && bus.i_enable && !bus.i_fifo_empty && (w_occ < 2'd2);
  assign w_hs        = r_cur_valid && bus.i_m_ready;
  assign w_word_done = w_hs && (r_byte_idx == LAST_IDX);
  assign w_shift     = r_cur >> {r_byte_idx, 3'b000};

  assign bus.o_fifo_rd_en = w_rd_en;
  assign bus.o_m_valid    = r_cur_valid;
  assign bus.o_m_data     = w_shift[7:0];
  assign bus.o_m_last     = r_cur_valid && (r_byte_idx == LAST_IDX);
  assign bus.o_busy       = r_cur_valid || r_pf_valid || r_pending;
  assign bus.o_word_cnt   = r_word_cnt;

  // Track the in-flight read and count every pop issued to the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= 1'b0;
      r_word_cnt <= 16'd0;
    end else begin
      r_pending <= w_rd_en;
      if (w_rd_en) begin
        r_word_cnt <= r_word_cnt + 16'd1;
      end
    end
  end

  // Advance through the current word, refill it on completion, and park arriving words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur       <= '0;
      r_pf        <= '0;
      r_cur_valid <= 1'b0;
      r_pf_valid  <= 1'b0;
      r_byte_idx  <= '0;
    end else if (w_word_done) begin
      r_byte_idx <= '0;
      if (r_pf_valid) begin
        // Prefetch moves up; a word landing this cycle refills the prefetch slot.
        r_cur      <= r_pf;
        r_pf_valid <= 1'b0;
        if (r_pending) begin
          r_pf       <= bus.i_fifo_data;
          r_pf_valid <= 1'b1;
        end
      end else if (r_pending) begin
        r_cur <= bus.i_fifo_data;
      end else begin
        r_cur_valid <= 1'b0;
      end
    end else begin
      if (w_hs) begin
        r_byte_idx <= r_byte_idx + IDXW'(1);
      end
      if (r_pending) begin
        if (!r_cur_valid) begin
          r_cur       <= bus.i_fifo_data;
          r_cur_valid <= 1'b1;
        end else begin
          r_pf       <= bus.i_fifo_data;
          r_pf_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_byte_reader.sv
// Directed bench for fifo_byte_reader.
// It uses a behavioural registered-read FIFO model and a byte scoreboard.
module tb_fifo_byte_reader;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic m_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_byte_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_byte_reader #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // FIFO model: read data appears the cycle after the pop strobe.
  logic [31:0] fifo_q[$];
  int          fifo_n = 0;
  logic [31:0] fifo_dout = '0;

  assign bus.i_enable     = enable;
  assign bus.i_m_ready    = m_ready;
  assign bus.i_fifo_empty = (fifo_n == 0);
  assign bus.i_fifo_data  = fifo_dout;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q.delete();
      fifo_n    <= 0;
      fifo_dout <= '0;
    end else if (bus.o_fifo_rd_en && fifo_q.size() > 0) begin
      fifo_dout <= fifo_q.pop_front();
      fifo_n    <= fifo_n - 1;
    end
  end

  // Scoreboard and monitor state.
  logic [7:0] exp_b[$];
  logic [7:0] rx_b[$];
  int         rx_c[$];
  logic       rx_l[$];
  int         cyc = 0;
  int         pop_cnt = 0;
  int         first_pop = -1;
  int         empty_err = 0;
  int         stab_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.o_fifo_rd_en) begin
      pop_cnt = pop_cnt + 1;
      if (first_pop < 0) first_pop = cyc;
    end
    if (bus.o_fifo_rd_en && bus.i_fifo_empty) empty_err = empty_err + 1;
    if (!rst && prev_stall &&
        (!bus.o_m_valid || bus.o_m_data != prev_data || bus.o_m_last != prev_last))
      stab_err = stab_err + 1;
    prev_stall = !rst && bus.o_m_valid && !m_ready;
    prev_data  = bus.o_m_data;
    prev_last  = bus.o_m_last;
    if (bus.o_m_valid && m_ready) begin
      rx_b.push_back(bus.o_m_data);
      rx_c.push_back(cyc);
      rx_l.push_back(bus.o_m_last);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rx_b.delete();
    rx_c.delete();
    rx_l.delete();
    pop_cnt   = 0;
    first_pop = -1;
    empty_err = 0;
    stab_err  = 0;
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    fifo_n = fifo_n + 1;
    for (int b = 0; b < 4; b++) exp_b.push_back(w[8*b +: 8]);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    enable  = 1'b0;
    m_ready = 1'b0;
    step();
    step();
    exp_b.delete();
    clear_logs();
    rst = 1'b0;
    step();
  endtask

  function automatic int rx_mismatch();
    int e = 0;
    if (rx_b.size() != exp_b.size()) e++;
    for (int i = 0; i < rx_b.size() && i < exp_b.size(); i++)
      if (rx_b[i] !== exp_b[i]) e++;
    return e;
  endfunction

  logic [31:0] stream_w[8] = '{32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                               32'hA3A2A1A0, 32'hB7B6B5B4, 32'hCBCAC9C8, 32'hFFEEDDCC};

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values.
    repeat (3) step();
    chk("rst_valid", bus.o_m_valid, 0);
    chk("rst_data",  bus.o_m_data, 8'h00);
    chk("rst_last",  bus.o_m_last, 0);
    chk("rst_rd_en", bus.o_fifo_rd_en, 0);
    chk("rst_busy",  bus.o_busy, 0);
    chk("rst_wcnt",  bus.o_word_cnt, 0);

    // Basic single word.
    do_reset();
    push(32'h44332211);
    m_ready = 1'b1;
    enable  = 1'b1;
    repeat (10) step();
    chk("basic_pops", pop_cnt, 1);
    chk("basic_nbytes", rx_b.size(), 4);
    if (rx_b.size() == 4) begin
      chk("basic_bytes", {rx_b[3], rx_b[2], rx_b[1], rx_b[0]}, 32'h44332211);
      chk("basic_latency", rx_c[0] - first_pop, 2);
      chk("basic_span", rx_c[3] - rx_c[0], 3);
      chk("basic_last", {28'd0, rx_l[3], rx_l[2], rx_l[1], rx_l[0]}, 32'h8);
    end
    chk("basic_busy", bus.o_busy, 0);
    chk("basic_wcnt", bus.o_word_cnt, 1);

    // Streaming eight words at full rate.
    do_reset();
    for (int i = 0; i < 8; i++) push(stream_w[i]);
    m_ready = 1'b1;
    enable  = 1'b1;
    repeat (45) step();
    chk("stream_nbytes", rx_b.size(), 32);
    chk("stream_order", rx_mismatch(), 0);
    if (rx_b.size() == 32) begin
      chk("stream_latency", rx_c[0] - first_pop, 2);
      chk("stream_span", rx_c[31] - rx_c[0], 31);
    end
    chk("stream_wcnt", bus.o_word_cnt, 8);
    chk("stream_empty_rd", empty_err, 0);

    // Backpressure: pops cap at two words, then random ready.
    do_reset();
    for (int i = 0; i < 6; i++) push(stream_w[i+2]);
    enable = 1'b1;
    repeat (10) step();
    chk("bp_hold_wcnt", bus.o_word_cnt, 2);
    chk("bp_hold_busy", bus.o_busy, 1);
    for (int i = 0; i < 300; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      step();
      if (rx_b.size() >= 24) break;
    end
    m_ready = 1'b0;
    chk("bp_nbytes", rx_b.size(), 24);
    chk("bp_order", rx_mismatch(), 0);
    chk("bp_stable", stab_err, 0);
    chk("bp_wcnt", bus.o_word_cnt, 6);

    // Underflow and refill.
    do_reset();
    push(32'h5A5B5C5D);
    push(32'h01234567);
    enable  = 1'b1;
    m_ready = 1'b1;
    repeat (15) step();
    chk("uf_valid", bus.o_m_valid, 0);
    chk("uf_nbytes", rx_b.size(), 8);
    chk("uf_busy", bus.o_busy, 0);
    push(32'h89ABCDEF);
    repeat (10) step();
    chk("uf_refill_nbytes", rx_b.size(), 12);
    chk("uf_order", rx_mismatch(), 0);
    chk("uf_empty_rd", empty_err, 0);
    chk("uf_wcnt", bus.o_word_cnt, 3);

    // Enable dropped with one read in flight.
    do_reset();
    for (int i = 0; i < 4; i++) push(stream_w[i]);
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pop_cnt >= 1) break;
    end
    enable = 1'b0;
    chk("en_pop_seen", pop_cnt, 1);
    repeat (6) step();
    chk("en_hold_wcnt", bus.o_word_cnt, 1);
    chk("en_landed", bus.o_m_valid, 1);
    m_ready = 1'b1;
    repeat (8) step();
    chk("en_drain_nbytes", rx_b.size(), 4);
    chk("en_drain_wcnt", bus.o_word_cnt, 1);
    chk("en_drain_busy", bus.o_busy, 0);
    enable = 1'b1;
    repeat (25) step();
    chk("en_resume_nbytes", rx_b.size(), 16);
    chk("en_resume_order", rx_mismatch(), 0);
    chk("en_resume_wcnt", bus.o_word_cnt, 4);

    // Reset mid-word with the prefetch slot full.
    do_reset();
    push(32'h13121110);
    push(32'h17161514);
    push(32'h1B1A1918);
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rx_b.size() >= 3) break;
    end
    chk("mid_busy_before", bus.o_busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.o_m_valid, 0);
    chk("mid_rst_data",  bus.o_m_data, 8'h00);
    chk("mid_rst_last",  bus.o_m_last, 0);
    chk("mid_rst_rd_en", bus.o_fifo_rd_en, 0);
    chk("mid_rst_busy",  bus.o_busy, 0);
    chk("mid_rst_wcnt",  bus.o_word_cnt, 0);
    step();
    exp_b.delete();
    clear_logs();
    rst = 1'b0;
    push(32'hDDCCBBAA);
    repeat (10) step();
    chk("mid_fresh_nbytes", rx_b.size(), 4);
    if (rx_b.size() == 4)
      chk("mid_fresh_bytes", {rx_b[3], rx_b[2], rx_b[1], rx_b[0]}, 32'hDDCCBBAA);
    chk("mid_fresh_wcnt", bus.o_word_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
